sat_accum_ctrl: RTL and testbench
=================================

SAT_ACCUM_CTRL -- requirements
Module: sat_accum_ctrl

Interface
REQ-001 Parameter W, 19, signed two's-complement data width of terms and sum.
REQ-002 Parameter N, 4, number of terms per accumulation burst (2..255).
REQ-003 Port CLK  in  1  single clock; all state changes on rising edge.
REQ-004 Port Reset  in  1  synchronous, active-high reset.
REQ-005 Port Start  in  1  one-cycle request to begin a new burst.
REQ-006 Port Term  in  W  signed operand offered to the shared adder.
REQ-007 Port TermValid  in  1  Term is valid this cycle.
REQ-008 Port TermReady  out  1  block accepts Term this cycle.
REQ-009 Port Sum  out  W  signed running and final accumulator value.
REQ-010 Port Done  out  1  one-cycle pulse: Sum holds the final burst result.
REQ-011 Port Busy  out  1  high while in ACCUM.
REQ-012 Port Sat  out  1  sticky: at least one addition of the current burst saturated.

Function
REQ-013 The block SHALL sequence one shared saturating adder (sat_add) computing Sum + Term per accepted term.
REQ-014 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-015 IDLE: TermReady=0, Busy=0; Start=1 clears Sum, Sat and the term counter, next state ACCUM.
REQ-016 ACCUM: TermReady=1, Busy=1; a transfer occurs when TermValid=1 and TermReady=1.
REQ-017 On each transfer Sum SHALL register the saturated result one edge later and the counter SHALL increment.
REQ-018 Cycles with TermValid=0 in ACCUM SHALL leave Sum, Sat and the counter unchanged (no timeout).
REQ-019 The transfer that makes the count equal N SHALL move the FSM to DONE; TermReady is 0 from the next cycle.
REQ-020 DONE: Done=1 for exactly one cycle, Busy=0, TermReady=0; next state IDLE unless Start=1.
REQ-021 Start=1 in DONE SHALL start a new burst (clear Sum/Sat/counter, next state ACCUM); Done still pulses that cycle.
REQ-022 Start in ACCUM SHALL be ignored.
REQ-023 Latency: Start at edge t gives TermReady=1 in cycle t+1; N-th transfer at edge k gives Done=1 and final Sum in cycle k+1.
REQ-024 Addition SHALL be computed at W+1 bits; result > 2^(W-1)-1 SHALL clamp to 19'h3FFFF (+262143), result < -2^(W-1) SHALL clamp to 19'h40000 (-262144).
REQ-025 Any clamp SHALL set Sat, which remains 1 until the next accepted Start or Reset.
REQ-026 After a clamp, accumulation SHALL continue from the clamped value (e.g. +max plus -1 yields +max-1).
REQ-027 Sum SHALL hold its final value through IDLE until the next accepted Start.
REQ-028 The counter SHALL be ceil(log2(N+1)) bits and SHALL NOT wrap within a burst.

Reset
REQ-029 Reset=1 at an edge SHALL force IDLE, Sum=0, counter=0, Sat=0, Done=0, Busy=0, TermReady=0, overriding Start and TermValid.
REQ-030 Reset mid-burst SHALL discard the partial sum; no Done pulse SHALL follow.

Structure
REQ-031 A shared package SHALL hold W, N defaults, the SAT_MAX/SAT_MIN constants and the FSM state typedef.
REQ-032 The saturating adder SHALL be the combinational sub-module sat_add (inputs a, b; output y), instantiated once.
REQ-033 All outputs except TermReady, Busy and Done SHALL be registered; those three SHALL decode from the state register only.

Verification
REQ-034 Start, terms 100, -50, 7, 3 back-to-back -> Done in cycle after 4th transfer, Sum=60, Sat=0.
REQ-035 Terms 200000, 100000, 0, 0 -> Sum=262143 after 2nd transfer, final Sum=262143, Sat=1.
REQ-036 Terms -200000, -100000, 5, 0 -> Sum=-262144, then -262139 final, Sat=1.
REQ-037 TermValid toggling 1,0,0,1,1,0,1 with terms 1 each -> Done only after 4 transfers, Sum=4; Start mid-burst ignored.
REQ-038 Reset asserted after 2 of 4 terms -> next cycle IDLE, Sum=0, no Done; fresh burst 1,1,1,1 gives Sum=4.
REQ-039 Start asserted in DONE cycle -> Done pulses once, Sum clears next cycle, TermReady=1 next cycle, Sat cleared.

Source files
------------

// File: rtl/sat_accum_ctrl_pkg.sv
// sat_accum_ctrl_pkg: shared widths, saturation limits and FSM state type
package sat_accum_ctrl_pkg;
    localparam int W_DEF = 19;
    localparam int N_DEF = 4;
    localparam logic signed [W_DEF-1:0] SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic signed [W_DEF-1:0] SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/sat_accum_ctrl_if.sv
// sat_accum_ctrl_if: burst handshake bundle
// master drives Start/Term/TermValid; slave drives TermReady/Sum/Done/Busy/Sat
interface sat_accum_ctrl_if
    import sat_accum_ctrl_pkg::*;
#(
    parameter int W = W_DEF
);
    logic                Start;
    logic signed [W-1:0] Term;
    logic                TermValid;
    logic                TermReady;
    logic signed [W-1:0] Sum;
    logic                Done;
    logic                Busy;
    logic                Sat;
    modport master (output Start, Term, TermValid, input TermReady, Sum, Done, Busy, Sat);
    modport slave  (input Start, Term, TermValid, output TermReady, Sum, Done, Busy, Sat);
endinterface

// File: rtl/sat_accum_ctrl_sat_add.sv
// sat_add: combinational signed adder clamping to the W-bit range
// a, b: operands; y: clamped sum; ovf: clamp occurred
module sat_add
    import sat_accum_ctrl_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                ovf
);
    logic signed [W:0] s;
    always_comb begin
        s   = {a[W-1], a} + {b[W-1], b};
        ovf = s[W] ^ s[W-1];
        y   = ovf ? (s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : s[W-1:0];
    end
endmodule

// File: rtl/sat_accum_ctrl.sv
// sat_accum_ctrl: N-term burst accumulator sequencing one shared saturating adder
// CLK, Reset: clock and sync active-high reset; bus: slave side of sat_accum_ctrl_if
module sat_accum_ctrl
    import sat_accum_ctrl_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input logic             CLK,
    input logic             Reset,
    sat_accum_ctrl_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    state_t              state;
    logic signed [W-1:0] sum_q;
    logic signed [W-1:0] y;
    logic                sat_q;
    logic                ovf;
    logic [CW-1:0]       cnt;
    sat_add #(.W(W)) u_add (.a(sum_q), .b(bus.Term), .y(y), .ovf(ovf));
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            sum_q <= '0;
            sat_q <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        state <= ACCUM;
                        sum_q <= '0;
                        sat_q <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCUM: begin
                    if (bus.TermValid) begin
                        sum_q <= y;
                        sat_q <= sat_q | ovf;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(N - 1)) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.TermReady = state == ACCUM;
    assign bus.Busy      = state == ACCUM;
    assign bus.Done      = state == DONE;
    assign bus.Sum       = sum_q;
    assign bus.Sat       = sat_q;
endmodule

// File: tb/tb_sat_accum_ctrl.sv
// tb_sat_accum_ctrl: randomized scoreboard bench for sat_accum_ctrl
module tb_sat_accum_ctrl;
    localparam int W = 19;
    localparam int N = 4;
    localparam int MAXV = (1 <<< (W - 1)) - 1;
    localparam int MINV = -(1 <<< (W - 1));
    typedef struct {
        int sum;
        bit sat;
        int cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t run_q[$];
    exp_t done_q[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   last_sum = 0;
    bit   last_sat = 1'b0;
    bit   pend = 1'b0;
    bit   mon_en = 1'b0;
    sat_accum_ctrl_if #(.W(W)) bus ();
    sat_accum_ctrl #(.W(W), .N(N)) dut (.CLK(clk), .Reset(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask
    always @(negedge clk) begin
        if (mon_en) begin
            if (pend) begin
                if (run_q.size() == 0) chk("run_underflow", 1, 0);
                else begin
                    chk("run_sum", int'(bus.Sum), run_q[0].sum);
                    chk("run_sat", int'(bus.Sat), int'(run_q[0].sat));
                    void'(run_q.pop_front());
                end
            end
            if (bus.Done) begin
                if (done_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    chk("done_sum", int'(bus.Sum), done_q[0].sum);
                    chk("done_sat", int'(bus.Sat), int'(done_q[0].sat));
                    chk("done_cycle", cyc, done_q[0].cyc);
                    void'(done_q.pop_front());
                end
            end else if (done_q.size() != 0 && done_q[0].cyc <= cyc) begin
                chk("done_missing", 0, 1);
                void'(done_q.pop_front());
            end
            pend <= bus.TermValid && bus.TermReady && !rst;
        end
    end
    task automatic burst(input int t[N], input int mode, input bit mid_start, input int abort_at);
        int s = 0;
        bit st = 1'b0;
        int i = 0;
        int k = 0;
        bit v;
        bit [6:0] pat = 7'b1011001;
        bus.Start = 1'b1;
        bus.TermValid = 1'b0;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        while (i < N) begin
            if (i == abort_at) begin
                rst = 1'b1;
                bus.Start = 1'b1;
                bus.TermValid = 1'b1;
                bus.Term = W'(1);
                @(posedge clk);
                #1;
                rst = 1'b0;
                bus.Start = 1'b0;
                bus.TermValid = 1'b0;
                @(negedge clk);
                chk("abort_sum", int'(bus.Sum), 0);
                chk("abort_sat", int'(bus.Sat), 0);
                chk("abort_busy", int'(bus.Busy), 0);
                chk("abort_ready", int'(bus.TermReady), 0);
                chk("abort_done", int'(bus.Done), 0);
                last_sum = 0;
                last_sat = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            v = (mode == 0) ? 1'b1 : (mode == 2) ? (k < 7 ? pat[k] : 1'b1) : ($urandom % 3 != 0);
            bus.TermValid = v;
            bus.Term = v ? W'(t[i]) : W'($urandom);
            bus.Start = mid_start && ($urandom % 2 == 1);
            if (v) begin
                s = s + t[i];
                if (s > MAXV) begin
                    s = MAXV;
                    st = 1'b1;
                end else if (s < MINV) begin
                    s = MINV;
                    st = 1'b1;
                end
                run_q.push_back('{s, st, 0});
                if (i == N - 1) done_q.push_back('{s, st, cyc + 1});
                i++;
            end
            if (k == 0) begin
                @(negedge clk);
                chk("start_sum", int'(bus.Sum), 0);
                chk("start_sat", int'(bus.Sat), 0);
                chk("start_ready", int'(bus.TermReady), 1);
                chk("start_busy", int'(bus.Busy), 1);
            end
            k++;
            @(posedge clk);
            #1;
        end
        bus.TermValid = 1'b0;
        bus.Start = 1'b0;
        last_sum = s;
        last_sat = st;
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            bus.Start = 1'b0;
            bus.TermValid = 1'($urandom % 2);
            bus.Term = W'($urandom);
            @(negedge clk);
            chk("hold_sum", int'(bus.Sum), last_sum);
            chk("hold_sat", int'(bus.Sat), int'(last_sat));
            chk("idle_ready", int'(bus.TermReady), 0);
            chk("idle_busy", int'(bus.Busy), 0);
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        int arr[N];
        bit chain;
        bus.Start = 1'b0;
        bus.TermValid = 1'b0;
        bus.Term = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_sum", int'(bus.Sum), 0);
        chk("reset_sat", int'(bus.Sat), 0);
        chk("reset_busy", int'(bus.Busy), 0);
        chk("reset_ready", int'(bus.TermReady), 0);
        chk("reset_done", int'(bus.Done), 0);
        @(posedge clk);
        #1;
        burst('{100, -50, 7, 3}, 0, 1'b0, N);
        idle(2);
        burst('{200000, 100000, 0, 0}, 0, 1'b0, N);
        idle(2);
        burst('{-200000, -100000, 5, 0}, 0, 1'b0, N);
        idle(2);
        burst('{1, 1, 1, 1}, 2, 1'b1, N);
        idle(2);
        burst('{1, 1, 1, 1}, 0, 1'b0, 2);
        burst('{1, 1, 1, 1}, 0, 1'b0, N);
        idle(1);
        burst('{262143, 5, -1, 0}, 1, 1'b0, N);
        burst('{1, 2, 3, 4}, 0, 1'b0, N);
        idle(2);
        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < N; j++)
                arr[j] = ($urandom % 2 == 1) ? int'($urandom % (1 << W)) + MINV : int'($urandom_range(0, 200)) - 100;
            chain = ($urandom % 3 == 0);
            burst(arr, 1, 1'($urandom % 2), ($urandom % 8 == 0) ? int'($urandom % N) : N);
            if (!chain) idle(int'($urandom_range(1, 3)));
        end
        idle(3);
        chk("done_q_empty", done_q.size(), 0);
        chk("run_q_empty", run_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
